// File: rtl/tabuleiro_pkg.sv
// Shared types and constants for the board transmitter.
// Build option TX_PARIDADE_EN selects 8E1 (11 bits per char) instead of 8N1.
package tabuleiro_pkg;

    localparam int N_CELULAS = 81;
    localparam int N_MACRO   = 9;
    localparam int FRAME_LEN = 92;

`ifdef TX_PARIDADE_EN
    localparam int BITS_POR_CHAR = 11;
`else
    localparam int BITS_POR_CHAR = 10;
`endif

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ENDERECO  = 4'd1,
        S_ESPERA    = 4'd2,
        S_CARREGA   = 4'd3,
        S_TRANSMITE = 4'd4,
        S_FIM       = 4'd5
    } estado_t;

    // Which part of the frame the current character belongs to.
    typedef enum logic [2:0] {
        FASE_ABRE,
        FASE_CELULA,
        FASE_MACRO,
        FASE_FECHA,
        FASE_FIM
    } fase_t;

    typedef enum logic [1:0] {
        CEL_VAZIO = 2'b00,
        CEL_X     = 2'b01,
        CEL_O     = 2'b10,
        CEL_VELHA = 2'b11
    } celula_t;

    localparam logic [7:0] ASCII_ABRE  = 8'h3C;
    localparam logic [7:0] ASCII_FECHA = 8'h3E;
    localparam logic [7:0] ASCII_VAZIO = 8'h2E;
    localparam logic [7:0] ASCII_X     = 8'h58;
    localparam logic [7:0] ASCII_O     = 8'h4F;
    localparam logic [7:0] ASCII_VELHA = 8'h23;

    function automatic logic [7:0] codifica(input logic [1:0] c);
        case (celula_t'(c))
            CEL_VAZIO: return ASCII_VAZIO;
            CEL_X:     return ASCII_X;
            CEL_O:     return ASCII_O;
            default:   return ASCII_VELHA;
        endcase
    endfunction

    function automatic logic [8:0] one_hot9(input logic [3:0] i);
        return 9'd1 << i;
    endfunction

endpackage

// File: rtl/transmissor_tabuleiro_tx_serial.sv
// Async serial shifter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Build option TX_PARIDADE_EN inserts the parity bit after data bit 7.
module tx_serial
    import tabuleiro_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] dado,
    output logic       serial,
    output logic       busy,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(BITS_POR_CHAR);

    logic [BITS_POR_CHAR-1:0] shift_q, shift_d;
    logic [CW-1:0]            clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
    logic                     busy_q, busy_d;
    logic [BITS_POR_CHAR-1:0] quadro;
    logic                     fim_bit;
    logic                     ultimo_bit;

`ifdef TX_PARIDADE_EN
    assign quadro = {1'b1, ^dado, dado, 1'b0};
`else
    assign quadro = {1'b1, dado, 1'b0};
`endif

    assign fim_bit    = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
    assign ultimo_bit = (bit_cnt_q == BW'(BITS_POR_CHAR - 1));
    assign done       = busy_q && fim_bit && ultimo_bit;
    // The idle shifter holds all ones, so the line is high straight out of reset.
    assign serial     = shift_q[0];
    assign busy       = busy_q;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        shift_d   = shift_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        busy_d    = busy_q;
        if (load && !busy_q) begin
            shift_d   = quadro;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            busy_d    = 1'b1;
        end else if (busy_q) begin
            if (fim_bit) begin
                clk_cnt_d = '0;
                if (ultimo_bit) begin
                    busy_d  = 1'b0;
                    shift_d = '1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    shift_d   = {1'b1, shift_q[BITS_POR_CHAR-1:1]};
                end
            end else begin
                clk_cnt_d = clk_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q   <= '1;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: rtl/transmissor_tabuleiro.sv
// Scans the 81 cells and 9 macro states from ram_board and sends them as an ASCII frame.
// Build option TX_PARIDADE_EN switches the serial line to 8E1.
module transmissor_tabuleiro
    import tabuleiro_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int READ_LAT     = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [1:0] estado_micro,
    input  logic [1:0] estado_macro,
    output logic [8:0] addr_macro,
    output logic [8:0] addr_micro,
    output logic       saida_serial,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    estado_t    estado_q, estado_d;
    fase_t      fase_q, fase_d;
    logic [3:0] macro_q, macro_d;
    logic [3:0] micro_q, micro_d;
    logic [1:0] espera_q, espera_d;
    logic [7:0] char_tx;
    logic       tx_load;
    logic       tx_busy;
    logic       tx_done;

    assign db_estado = estado_q;

    always_comb begin
        case (fase_q)
            FASE_ABRE:   char_tx = ASCII_ABRE;
            FASE_CELULA: char_tx = codifica(estado_micro);
            FASE_MACRO:  char_tx = codifica(estado_macro);
            default:     char_tx = ASCII_FECHA;
        endcase
    end

    // Address held from ENDERECO through CARREGA; delimiters keep it at zero.
    always_comb begin
        addr_macro = '0;
        addr_micro = '0;
        if (estado_q == S_ENDERECO || estado_q == S_ESPERA || estado_q == S_CARREGA) begin
            if (fase_q == FASE_CELULA) begin
                addr_macro = one_hot9(macro_q);
                addr_micro = one_hot9(micro_q);
            end else if (fase_q == FASE_MACRO) begin
                addr_macro = one_hot9(macro_q);
            end
        end
    end

    always_comb begin
        estado_d = estado_q;
        fase_d   = fase_q;
        macro_d  = macro_q;
        micro_d  = micro_q;
        espera_d = espera_q;
        ocupado  = 1'b0;
        pronto   = 1'b0;
        tx_load  = 1'b0;
        case (estado_q)
            S_IDLE: begin
                if (partida) begin
                    estado_d = S_ENDERECO;
                    fase_d   = FASE_ABRE;
                    macro_d  = '0;
                    micro_d  = '0;
                end
            end
            S_ENDERECO: begin
                ocupado  = 1'b1;
                espera_d = '0;
                estado_d = S_ESPERA;
            end
            S_ESPERA: begin
                ocupado = 1'b1;
                if (espera_q == 2'(READ_LAT - 1)) estado_d = S_CARREGA;
                else                               espera_d = espera_q + 2'd1;
            end
            S_CARREGA: begin
                ocupado  = 1'b1;
                tx_load  = !tx_busy;
                estado_d = S_TRANSMITE;
                // Step to the next character: cells macro-major, then macro states.
                case (fase_q)
                    FASE_ABRE: fase_d = FASE_CELULA;
                    FASE_CELULA: begin
                        if (micro_q == 4'd8) begin
                            micro_d = '0;
                            if (macro_q == 4'd8) begin
                                macro_d = '0;
                                fase_d  = FASE_MACRO;
                            end else begin
                                macro_d = macro_q + 4'd1;
                            end
                        end else begin
                            micro_d = micro_q + 4'd1;
                        end
                    end
                    FASE_MACRO: begin
                        if (macro_q == 4'd8) begin
                            macro_d = '0;
                            fase_d  = FASE_FECHA;
                        end else begin
                            macro_d = macro_q + 4'd1;
                        end
                    end
                    default: fase_d = FASE_FIM;
                endcase
            end
            S_TRANSMITE: begin
                ocupado = 1'b1;
                if (tx_done) estado_d = (fase_q == FASE_FIM) ? S_FIM : S_ENDERECO;
            end
            S_FIM: begin
                pronto   = 1'b1;
                estado_d = S_IDLE;
            end
            default: estado_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= S_IDLE;
            fase_q   <= FASE_ABRE;
            macro_q  <= '0;
            micro_q  <= '0;
            espera_q <= '0;
        end else begin
            estado_q <= estado_d;
            fase_q   <= fase_d;
            macro_q  <= macro_d;
            micro_q  <= micro_d;
            espera_q <= espera_d;
        end
    end

    tx_serial #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clock (clock),
        .reset (reset),
        .load  (tx_load),
        .dado  (char_tx),
        .serial(saida_serial),
        .busy  (tx_busy),
        .done  (tx_done)
    );

endmodule

// File: tb/tb_transmissor_tabuleiro.sv
// Directed bench for transmissor_tabuleiro: scripted RAM, serial decoder, address and pronto monitors.
// Expected frame timing follows TX_PARIDADE_EN when that macro is defined.
`timescale 1ns/1ps
module tb_transmissor_tabuleiro;

    localparam int CPB = 4;
    localparam int RL  = 1;
`ifdef TX_PARIDADE_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int T_CH    = NB * CPB + 2 + RL;
    localparam int T_FRAME = 92 * T_CH;

    logic       clock;
    logic       reset;
    logic       partida;
    logic [1:0] estado_micro;
    logic [1:0] estado_macro;
    logic [8:0] addr_macro;
    logic [8:0] addr_micro;
    logic       saida_serial;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [1:0] mem_cel [0:80];
    logic [1:0] mem_mac [0:8];

    logic [7:0] rx_q [$];
    logic [7:0] rx_b;
`ifdef TX_PARIDADE_EN
    logic       rx_p;
`endif
    int stop_err = 0;
    int par_err  = 0;

    int car_cnt       = 0;
    int car_last      = 0;
    int addr_err      = 0;
    int idle_addr_err = 0;
    int pronto_cnt    = 0;

    transmissor_tabuleiro #(
        .CLKS_PER_BIT(CPB),
        .READ_LAT    (RL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .partida     (partida),
        .estado_micro(estado_micro),
        .estado_macro(estado_macro),
        .addr_macro  (addr_macro),
        .addr_micro  (addr_micro),
        .saida_serial(saida_serial),
        .ocupado     (ocupado),
        .pronto      (pronto),
        .db_estado   (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int dec9(input logic [8:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 9; i++) if (v == (9'd1 << i)) r = i;
        return r;
    endfunction

    function automatic logic [1:0] ram_cel(input logic [8:0] am, input logic [8:0] au);
        int m;
        int u;
        m = dec9(am);
        u = dec9(au);
        if (m < 0 || u < 0) return 2'b11;
        return mem_cel[m * 9 + u];
    endfunction

    function automatic logic [1:0] ram_mac(input logic [8:0] am);
        int m;
        m = dec9(am);
        if (m < 0) return 2'b11;
        return mem_mac[m];
    endfunction

    // Read latency of one cycle; invalid addresses return 11 so stale reads show up as '#'.
    always @(posedge clock) begin
        estado_micro <= ram_cel(addr_macro, addr_micro);
        estado_macro <= ram_mac(addr_macro);
    end

    function automatic logic [7:0] enc(input logic [1:0] c);
        case (c)
            2'b00:   return 8'h2E;
            2'b01:   return 8'h58;
            2'b10:   return 8'h4F;
            default: return 8'h23;
        endcase
    endfunction

    function automatic logic [7:0] exp_char(input int k);
        if (k == 0) return 8'h3C;
        if (k <= 81) return enc(mem_cel[k - 1]);
        if (k <= 90) return enc(mem_mac[k - 82]);
        return 8'h3E;
    endfunction

    function automatic logic [8:0] exp_am(input int k);
        if (k >= 1 && k <= 81) return 9'd1 << ((k - 1) / 9);
        if (k >= 82 && k <= 90) return 9'd1 << (k - 82);
        return 9'd0;
    endfunction

    function automatic logic [8:0] exp_au(input int k);
        if (k >= 1 && k <= 81) return 9'd1 << ((k - 1) % 9);
        return 9'd0;
    endfunction

    // Serial decoder: samples mid-bit on falling clock edges.
    initial begin : rx
        forever begin
            @(negedge clock);
            if (saida_serial === 1'b0) begin
                repeat (CPB / 2) @(negedge clock);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clock);
                    rx_b[i] = saida_serial;
                end
`ifdef TX_PARIDADE_EN
                repeat (CPB) @(negedge clock);
                rx_p = saida_serial;
                if (rx_p !== ^rx_b) par_err = par_err + 1;
`endif
                repeat (CPB) @(negedge clock);
                if (saida_serial !== 1'b1) stop_err = stop_err + 1;
                rx_q.push_back(rx_b);
            end
        end
    end

    // Address and pronto monitor.
    always @(negedge clock) begin
        if (pronto === 1'b1) pronto_cnt <= pronto_cnt + 1;
        if (db_estado == 4'd0) begin
            car_cnt <= 0;
            if (addr_macro !== 9'd0 || addr_micro !== 9'd0) idle_addr_err <= idle_addr_err + 1;
        end else if (db_estado == 4'd1 || db_estado == 4'd3) begin
            if (addr_macro !== exp_am(car_cnt) || addr_micro !== exp_au(car_cnt))
                addr_err <= addr_err + 1;
            if (db_estado == 4'd3) car_cnt <= car_cnt + 1;
        end else if (db_estado == 4'd5) begin
            car_last <= car_cnt;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is at a falling edge in IDLE; returns at the falling edge where pronto is seen.
    task automatic run_frame(input int pulse_a, input int pulse_b, output int dur,
                             output logic ocup_ini, output logic ocup_fim, output logic ok);
        int acc;
        int i;
        partida = 1'b1;
        @(negedge clock);
        partida  = 1'b0;
        acc      = cyc;
        ocup_ini = ocupado;
        i = 0;
        while (pronto !== 1'b1 && i < T_FRAME + 200) begin
            partida = (i == pulse_a || i == pulse_b) ? 1'b1 : 1'b0;
            @(negedge clock);
            i++;
        end
        partida  = 1'b0;
        ok       = (pronto === 1'b1);
        dur      = cyc - acc;
        ocup_fim = ocupado;
    endtask

    task automatic check_frame(input string tag, input int base);
        int bad;
        bad = 0;
        check({tag, "_len"}, rx_q.size() - base, 92);
        for (int k = 0; k < 92; k++) begin
            if (base + k < rx_q.size()) begin
                if (rx_q[base + k] !== exp_char(k)) bad++;
            end else begin
                bad++;
            end
        end
        check({tag, "_chars"}, bad, 0);
    endtask

    initial begin : main
        int   dur;
        logic oi;
        logic of;
        logic ok;
        int   base;
        int   p0;
        int   i;

        reset   = 1'b1;
        partida = 1'b0;
        for (int k = 0; k < 81; k++) mem_cel[k] = 2'b00;
        for (int k = 0; k < 9; k++)  mem_mac[k] = 2'b00;
        repeat (3) @(negedge clock);

        check("rst_serial", saida_serial, 1);
        check("rst_ocupado", ocupado, 0);
        check("rst_pronto", pronto, 0);
        check("rst_addr_macro", addr_macro, 0);
        check("rst_addr_micro", addr_micro, 0);
        check("rst_estado", db_estado, 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // Empty board.
        base = rx_q.size();
        run_frame(-1, -1, dur, oi, of, ok);
        check("t1_pronto_seen", ok, 1);
        check("t1_ocupado_ini", oi, 1);
        check("t1_duracao", dur, T_FRAME);
        check("t1_ocupado_em_fim", of, 0);
        partida = 1'b1;
        @(negedge clock);
        check("t1_pronto_1ciclo", pronto, 0);
        partida = 1'b0;
        @(negedge clock);
        check("t1_partida_em_fim_ignorada", db_estado, 0);
        check("t1_ocupado_apos", ocupado, 0);
        repeat (5) @(negedge clock);
        check_frame("t1", base);
        check("t1_n_carrega", car_last, 92);

        // X at m4u4, O at m0u8, macro m2 drawn.
        mem_cel[40] = 2'b01;
        mem_cel[8]  = 2'b10;
        mem_mac[2]  = 2'b11;
        base = rx_q.size();
        run_frame(-1, -1, dur, oi, of, ok);
        check("t2_pronto_seen", ok, 1);
        check("t2_duracao", dur, T_FRAME);
        // Next partida in the very next IDLE cycle after FIM.
        @(negedge clock);
        check_frame("t2", base);
        check("t2_char41_X", rx_q[base + 41], 8'h58);
        check("t2_char9_O", rx_q[base + 9], 8'h4F);
        check("t2_char84_hash", rx_q[base + 84], 8'h23);
        check("t2_char0_abre", rx_q[base], 8'h3C);
        check("t2_char91_fecha", rx_q[base + 91], 8'h3E);

        // partida pulses mid-frame must be ignored.
        p0   = pronto_cnt;
        base = rx_q.size();
        run_frame(100, 2000, dur, oi, of, ok);
        check("t4_aceite_imediato", oi, 1);
        check("t4_duracao", dur, T_FRAME);
        repeat (200) @(negedge clock);
        check("t4_um_pronto", pronto_cnt - p0, 1);
        check("t4_idle", db_estado, 0);
        check_frame("t4", base);

        // Reset in the middle of a character.
        p0 = pronto_cnt;
        partida = 1'b1;
        @(negedge clock);
        partida = 1'b0;
        repeat (1500) @(negedge clock);
        i = 0;
        while (saida_serial !== 1'b0 && i < 200) begin
            @(negedge clock);
            i++;
        end
        check("t5_linha_baixa", saida_serial, 0);
        #2 reset = 1'b1;
        #1;
        check("t5_reset_serial", saida_serial, 1);
        check("t5_reset_ocupado", ocupado, 0);
        check("t5_reset_addr", {addr_macro, addr_micro}, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (3 * T_CH) @(negedge clock);
        check("t5_sem_pronto", pronto_cnt - p0, 0);
        check("t5_idle", db_estado, 0);
        base = rx_q.size();
        run_frame(-1, -1, dur, oi, of, ok);
        check("t5_pronto_seen", ok, 1);
        check("t5_duracao", dur, T_FRAME);
        repeat (5) @(negedge clock);
        check_frame("t5", base);

        check("addr_varredura", addr_err, 0);
        check("addr_idle", idle_addr_err, 0);
        check("stop_bits", stop_err, 0);
`ifdef TX_PARIDADE_EN
        check("paridade", par_err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
